// File: rtl/reg_io_pkg.sv
// Shared types and defaults for the register read serializer.
// State encoding, default word width, counter sizing helper.
package reg_io_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A 1-bit word still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register, MSB first.
// Load has priority; shift moves left with zero fill.
module shift_reg_piso
  import reg_io_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  // Capture a new word or advance one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_d;
    end else if (i_shift) begin
      r_data <= r_data << 1;
    end
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/reg_read_serializer.sv
// Serializes a parallel register word onto a bit stream.
// Moore FSM with registered handshake outputs.
module reg_read_serializer
  import reg_io_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  ser_data,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  done
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req_ready;
  logic          r_ser_valid;
  logic          r_done;

  logic w_accept;
  logic w_hs;
  logic w_last;

  // r_req_ready is only ever set while idle, so it gates accepts.
  assign w_accept = r_req_ready & req_valid;
  assign w_hs     = r_ser_valid & ser_ready;
  assign w_last   = (r_cnt == '0);

  shift_reg_piso #(
    .WIDTH(DATA_WIDTH)
  ) u_sr (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (w_accept),
    .i_shift(w_hs),
    .i_d    (in),
    .o_msb  (ser_data)
  );

  // State, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done      <= 1'b0;
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_state     <= ST_SHIFT;
            r_cnt       <= CNT_LOAD;
            r_req_ready <= 1'b0;
            r_ser_valid <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_hs) begin
            if (w_last) begin
              r_state     <= ST_DONE;
              r_ser_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_done      <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_ser_valid <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign ser_valid = r_ser_valid;
  assign done      = r_done;

endmodule
